// File: rtl/bus_guard_pkg.sv
// Shared types and constants for the bus timeout guard.
// Imported by the guard RTL and its bench.
package bus_guard_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ABORT,
        GAP
    } guard_state_e;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
    localparam int          ERR_CNT_W     = 8;

    // Error counter sticks at all-ones rather than wrapping back to zero.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/bus_timeout_guard_if.sv
// Core-side and bus-side transfer signals around the timeout guard.
// The guard uses the slave modport; the surrounding core/bus uses master.
interface bus_timeout_guard_if;

    logic        core_valid_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic [3:0]  core_wstrb_i;
    logic [31:0] core_rdata_o;
    logic        core_ready_o;
    logic        bus_valid_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ready_i;

    modport slave (
        input  core_valid_i, core_addr_i, core_wdata_i, core_wstrb_i,
        input  bus_rdata_i, bus_ready_i,
        output core_rdata_o, core_ready_o,
        output bus_valid_o, bus_addr_o, bus_wdata_o, bus_wstrb_o
    );

    modport master (
        output core_valid_i, core_addr_i, core_wdata_i, core_wstrb_i,
        output bus_rdata_i, bus_ready_i,
        input  core_rdata_o, core_ready_o,
        input  bus_valid_o, bus_addr_o, bus_wdata_o, bus_wstrb_o
    );

endinterface

// File: rtl/bus_timeout_guard.sv
// Zero-latency pass-through between core and bus that aborts any access whose
// slave fails to answer within TIMEOUT_CYC cycles, logging and flagging it.
module bus_timeout_guard
    import bus_guard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    bus_timeout_guard_if.slave   gif,
    input  logic                 err_clr_i,
    output logic                 err_irq_o,
    output logic [31:0]          err_addr_o,
    output logic                 err_we_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    guard_state_e         state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [31:0]          err_addr_nxt;
    logic                 err_we_nxt;
    logic [ERR_CNT_W-1:0] err_cnt_nxt;

    assign gif.bus_addr_o  = gif.core_addr_i;
    assign gif.bus_wdata_o = gif.core_wdata_i;
    assign gif.bus_wstrb_o = gif.core_wstrb_i;

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        err_addr_nxt     = err_addr_o;
        err_we_nxt       = err_we_o;
        err_cnt_nxt      = err_cnt_o;
        gif.bus_valid_o  = gif.core_valid_i;
        gif.core_ready_o = gif.bus_ready_i & gif.core_valid_i;
        gif.core_rdata_o = gif.bus_rdata_i;
        err_irq_o        = 1'b0;

        // Clear is applied first so an abort in the same cycle still records.
        if (err_clr_i) begin
            err_addr_nxt = '0;
            err_we_nxt   = 1'b0;
            err_cnt_nxt  = '0;
        end

        unique case (state)
            IDLE: begin
                if (gif.core_valid_i && !gif.bus_ready_i) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (gif.bus_ready_i || !gif.core_valid_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ABORT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            ABORT: begin
                gif.bus_valid_o  = 1'b0;
                gif.core_ready_o = 1'b1;
                gif.core_rdata_o = ERR_RDATA;
                err_irq_o        = 1'b1;
                err_addr_nxt     = gif.core_addr_i;
                err_we_nxt       = |gif.core_wstrb_i;
                err_cnt_nxt      = sat_inc(err_cnt_nxt);
                state_nxt        = GAP;
            end
            GAP: begin
                // A late ready from the abandoned slave is swallowed here.
                gif.bus_valid_o  = 1'b0;
                gif.core_ready_o = 1'b0;
                state_nxt        = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (!rst_n_i) begin
            gif.bus_valid_o  = 1'b0;
            gif.core_ready_o = 1'b0;
            err_irq_o        = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            cnt        <= '0;
            err_addr_o <= '0;
            err_we_o   <= 1'b0;
            err_cnt_o  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            err_addr_o <= err_addr_nxt;
            err_we_o   <= err_we_nxt;
            err_cnt_o  <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_bus_timeout_guard.sv
// Directed bench for bus_timeout_guard with TIMEOUT_CYC=8: a per-cycle
// reference model plus hand-computed spot values for each scenario.
module tb_bus_timeout_guard;
    import bus_guard_pkg::*;

    localparam int unsigned TO   = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        err_clr;
    logic        err_irq;
    logic [31:0] err_addr;
    logic        err_we;
    logic [7:0]  err_cnt;

    bus_timeout_guard_if gif();

    bus_timeout_guard #(
        .TIMEOUT_CYC (TO),
        .ERR_RDATA   (ERRD)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .gif        (gif),
        .err_clr_i  (err_clr),
        .err_irq_o  (err_irq),
        .err_addr_o (err_addr),
        .err_we_o   (err_we),
        .err_cnt_o  (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    // Reference model: how many consecutive cycles the current request has
    // been left unanswered, whether the previous cycle was an abort, and the
    // error log as plain integers.
    int          age    = 0;
    bit          in_gap = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_addr = '0;
    logic        m_we   = 1'b0;
    bit          m_ab;
    logic [31:0] e_rdata;
    logic        e_bv, e_cr, e_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        m_ab    = (age == int'(TO));
        e_rdata = m_ab ? ERRD : gif.bus_rdata_i;
        e_bv    = rst_n && !m_ab && !in_gap && gif.core_valid_i;
        e_cr    = rst_n && (m_ab || (!in_gap && gif.core_valid_i && gif.bus_ready_i));
        e_irq   = rst_n && m_ab;
        if (run_cmp) begin
            chk("m_bus_valid",  32'(gif.bus_valid_o),  32'(e_bv));
            chk("m_core_ready", 32'(gif.core_ready_o), 32'(e_cr));
            chk("m_core_rdata", gif.core_rdata_o,      e_rdata);
            chk("m_bus_addr",   gif.bus_addr_o,        gif.core_addr_i);
            chk("m_bus_wdata",  gif.bus_wdata_o,       gif.core_wdata_i);
            chk("m_bus_wstrb",  32'(gif.bus_wstrb_o),  32'(gif.core_wstrb_i));
            chk("m_err_irq",    32'(err_irq),          32'(e_irq));
            chk("m_err_cnt",    32'(err_cnt),          32'(m_cnt));
            chk("m_err_addr",   err_addr,              m_addr);
            chk("m_err_we",     32'(err_we),           32'(m_we));
        end
        if (!rst_n) begin
            age = 0; in_gap = 1'b0; m_cnt = 0; m_addr = '0; m_we = 1'b0;
        end else begin
            if (err_clr) begin
                m_cnt = 0; m_addr = '0; m_we = 1'b0;
            end
            if (m_ab) begin
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_addr = gif.core_addr_i;
                m_we   = |gif.core_wstrb_i;
                age    = 0;
                in_gap = 1'b1;
            end else if (in_gap) begin
                in_gap = 1'b0;
                age    = 0;
            end else if (gif.core_valid_i && !gif.bus_ready_i) begin
                age = age + 1;
            end else begin
                age = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        gif.core_valid_i = 1'b0;
        gif.bus_ready_i  = 1'b0;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        gif.core_valid_i = 1'b1;
        gif.core_addr_i  = a;
        gif.core_wdata_i = wd;
        gif.core_wstrb_i = ws;
    endtask

    // Request issued in cycle 0, never answered; abort lands in cycle TO.
    task automatic do_abort(input logic [31:0] a, input logic [3:0] ws, input logic clr);
        step();
        req(a, 32'h0, ws);
        repeat (TO) step();
        err_clr = clr;
        step();
        idle_bus();
        err_clr = 1'b0;
        step();
    endtask

    initial begin
        rst_n            = 1'b0;
        err_clr          = 1'b0;
        gif.core_valid_i = 1'b1;
        gif.core_addr_i  = 32'h0000_0100;
        gif.core_wdata_i = 32'h0;
        gif.core_wstrb_i = 4'h0;
        gif.bus_rdata_i  = 32'h5555_AAAA;
        gif.bus_ready_i  = 1'b1;

        step();
        run_cmp = 1'b1;
        @(negedge clk);
        chk("rst_bus_valid",  32'(gif.bus_valid_o),  32'd0);
        chk("rst_core_ready", 32'(gif.core_ready_o), 32'd0);
        chk("rst_err_cnt",    32'(err_cnt),          32'd0);
        chk("rst_err_addr",   err_addr,              32'd0);
        step();
        rst_n = 1'b1;
        idle_bus();
        step();

        // Read answered in cycle 3
        req(32'h0300_0000, 32'h0, 4'h0);
        repeat (3) step();
        gif.bus_ready_i = 1'b1;
        gif.bus_rdata_i = 32'h1234_5678;
        @(negedge clk);
        chk("t1_core_ready", 32'(gif.core_ready_o), 32'd1);
        chk("t1_core_rdata", gif.core_rdata_o,      32'h1234_5678);
        chk("t1_err_irq",    32'(err_irq),          32'd0);
        step();
        idle_bus();

        // Unanswered write aborts in cycle 8
        step();
        req(32'h0400_0010, 32'hA5A5_0001, 4'hF);
        repeat (7) step();
        @(negedge clk);
        chk("t2_valid_c7", 32'(gif.bus_valid_o), 32'd1);
        step();
        @(negedge clk);
        chk("t2_bus_valid",  32'(gif.bus_valid_o),  32'd0);
        chk("t2_core_ready", 32'(gif.core_ready_o), 32'd1);
        chk("t2_core_rdata", gif.core_rdata_o,      32'hDEAD_BEEF);
        chk("t2_err_irq",    32'(err_irq),          32'd1);
        step();
        idle_bus();
        @(negedge clk);
        chk("t2_irq_once", 32'(err_irq),  32'd0);
        chk("t2_err_addr", err_addr,      32'h0400_0010);
        chk("t2_err_we",   32'(err_we),   32'd1);
        chk("t2_err_cnt",  32'(err_cnt),  32'd1);
        step();

        // Ready in the expiry cycle wins
        req(32'h0300_0040, 32'h0, 4'h0);
        repeat (7) step();
        gif.bus_ready_i = 1'b1;
        gif.bus_rdata_i = 32'hCAFE_0001;
        @(negedge clk);
        chk("t3_core_ready", 32'(gif.core_ready_o), 32'd1);
        chk("t3_core_rdata", gif.core_rdata_o,      32'hCAFE_0001);
        chk("t3_err_irq",    32'(err_irq),          32'd0);
        step();
        idle_bus();
        @(negedge clk);
        chk("t3_err_cnt", 32'(err_cnt), 32'd1);
        step();

        // Late ready during the gap, back-to-back request after abort
        req(32'h0400_0020, 32'h0, 4'h0);
        repeat (TO) step();
        step();
        gif.bus_ready_i = 1'b1;
        req(32'h0500_0000, 32'h0, 4'h0);
        @(negedge clk);
        chk("t4_gap_valid", 32'(gif.bus_valid_o),  32'd0);
        chk("t4_gap_ready", 32'(gif.core_ready_o), 32'd0);
        step();
        gif.bus_ready_i = 1'b0;
        @(negedge clk);
        chk("t4_fwd_valid", 32'(gif.bus_valid_o),  32'd1);
        chk("t4_fwd_addr",  gif.bus_addr_o,        32'h0500_0000);
        step();
        gif.bus_ready_i = 1'b1;
        gif.bus_rdata_i = 32'h0000_0B0B;
        @(negedge clk);
        chk("t4_done", 32'(gif.core_ready_o), 32'd1);
        step();
        idle_bus();
        @(negedge clk);
        chk("t4_err_cnt",  32'(err_cnt), 32'd2);
        chk("t4_err_addr", err_addr,     32'h0400_0020);
        chk("t4_err_we",   32'(err_we),  32'd0);

        // Clear coincident with abort, then saturation
        for (int i = 0; i < 3; i++) do_abort(32'h0600_0000 + 32'(i), 4'h1, 1'b0);
        @(negedge clk);
        chk("t5_cnt5", 32'(err_cnt), 32'd5);
        do_abort(32'h0600_0004, 4'h0, 1'b1);
        @(negedge clk);
        chk("t5_clr_cnt",  32'(err_cnt), 32'd1);
        chk("t5_clr_addr", err_addr,     32'h0600_0004);
        chk("t5_clr_we",   32'(err_we),  32'd0);
        for (int i = 0; i < 260; i++) do_abort(32'h0700_0000 + 32'(i), 4'h2, 1'b0);
        @(negedge clk);
        chk("t5_sat_cnt",  32'(err_cnt), 32'hFF);
        chk("t5_sat_addr", err_addr,     32'h0700_0103);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("t5_clr_idle", 32'(err_cnt), 32'd0);

        // Reset while waiting at cnt=5, then a full-length timeout
        do_abort(32'h0800_0000, 4'h8, 1'b0);
        req(32'h0900_0000, 32'h0, 4'h0);
        repeat (5) step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", 32'(gif.bus_valid_o),  32'd0);
        chk("t6_rst_ready", 32'(gif.core_ready_o), 32'd0);
        chk("t6_rst_irq",   32'(err_irq),          32'd0);
        step();
        rst_n = 1'b1;
        idle_bus();
        @(negedge clk);
        chk("t6_err_cnt",  32'(err_cnt), 32'd0);
        chk("t6_err_addr", err_addr,     32'd0);
        chk("t6_err_we",   32'(err_we),  32'd0);
        step();
        req(32'h0A00_0000, 32'h0, 4'h3);
        repeat (7) step();
        @(negedge clk);
        chk("t6_c7_ready", 32'(gif.core_ready_o), 32'd0);
        step();
        @(negedge clk);
        chk("t6_c8_ready", 32'(gif.core_ready_o), 32'd1);
        chk("t6_c8_irq",   32'(err_irq),          32'd1);
        step();
        idle_bus();
        @(negedge clk);
        chk("t6_err_cnt1", 32'(err_cnt), 32'd1);
        chk("t6_err_we1",  32'(err_we),  32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
